nus_capture_ctrl: RTL and testbench

NUS_CAPTURE_CTRL -- requirements
Module: nus_capture_ctrl

---
 rtl/nus_pkg.sv | 20 ++
 rtl/nus_valid_pipe.sv | 38 +++
 rtl/nus_capture_ctrl.sv | 131 +++++++++++++
 tb/tb_nus_capture_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/nus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nus_pkg : shared types and constants for the NUS capture path        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package nus_pkg;

   localparam int NUS_WORD_W = 75;
   localparam int SAMPLE_W   = 9;
   localparam int PARSE_LAT  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ERR   = 2'd3
   } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/nus_valid_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nus_valid_pipe : valid/first-word tag shift register, sync flush     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nus_valid_pipe #(
   parameter int DEPTH = 4
) (
   input  logic             clk_sys,
   input  logic             resetb,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             in_tag,
   output logic [DEPTH-1:0] valid_q,
   output logic             tag_last
);

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_tag;

   always_ff @(posedge clk_sys or negedge resetb) begin
      if (!resetb) begin
         r_valid <= '0;
         r_tag   <= '0;
      end else if (flush) begin
         r_valid <= '0;
         r_tag   <= '0;
      end else begin
         r_valid <= {r_valid[DEPTH-2:0], in_valid};
         r_tag   <= {r_tag[DEPTH-2:0], in_tag & in_valid};
      end
   end

   assign valid_q  = r_valid;
   assign tag_last = r_tag[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/nus_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nus_capture_ctrl : FIFO pop control and parser valid timing for NUS  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nus_capture_ctrl
   import nus_pkg::*;
#(
   parameter int FIFO_RD_LAT = 1
) (
   input  logic        clk_sys,
   input  logic        resetb,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic [15:0] burst_len,
   input  logic        fifo_empty,
   input  logic        fifo_ovf,
   output logic        fifo_rd_en,
   output logic        parse_valid,
   output logic        dt_valid,
   output logic        dt0_valid,
   output logic        busy,
   output logic        done,
   output logic [15:0] word_cnt,
   output logic        err_ovf
);

   localparam int VALID_DEPTH = FIFO_RD_LAT + PARSE_LAT + 1;
   localparam int PARSE_TAP   = FIFO_RD_LAT + PARSE_LAT - 1;

   cap_state_t             r_state;
   cap_state_t             w_state_next;
   logic [1:0]             r_rst_sync;
   logic                   w_rstn;
   logic                   w_rd_en;
   logic                   w_flush;
   logic                   w_first;
   logic                   w_tag_last;
   logic [VALID_DEPTH-1:0] w_valid_q;
   logic [15:0]            r_word_cnt;
   logic [15:0]            r_burst_len;
   logic                   r_err_ovf;
   logic                   r_done;

   // Reset asserts immediately, releases on a clock edge.
   always_ff @(posedge clk_sys or negedge resetb) begin
      if (!resetb) r_rst_sync <= 2'b00;
      else         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rstn = r_rst_sync[1];

   always_comb begin
      w_state_next = r_state;
      w_rd_en      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !stop) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            w_rd_en = !fifo_empty && !stop;
            if (fifo_ovf)
               w_state_next = ST_ERR;
            else if (stop)
               w_state_next = ST_DRAIN;
            else if (w_rd_en && (r_burst_len != 16'd0) && (r_word_cnt == r_burst_len - 16'd1))
               w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Leave once nothing but the final stage is still in flight.
            if (fifo_ovf)
               w_state_next = ST_ERR;
            else if (!(|w_valid_q[VALID_DEPTH-2:0]))
               w_state_next = ST_IDLE;
         end
         ST_ERR: begin
            if (clear) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_flush = (w_state_next == ST_ERR);
   assign w_first = (r_word_cnt == 16'd0);

   always_ff @(posedge clk_sys or negedge w_rstn) begin
      if (!w_rstn) begin
         r_state     <= ST_IDLE;
         r_word_cnt  <= 16'd0;
         r_burst_len <= 16'd0;
         r_err_ovf   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= (r_state == ST_DRAIN) && (w_state_next == ST_IDLE);
         if (r_state == ST_IDLE && w_state_next == ST_RUN) begin
            r_word_cnt  <= 16'd0;
            r_burst_len <= burst_len;
         end else if (w_rd_en && r_word_cnt != 16'hFFFF) begin
            r_word_cnt <= r_word_cnt + 16'd1;
         end
         if (w_state_next == ST_ERR && r_state != ST_ERR)
            r_err_ovf <= 1'b1;
         else if (r_state == ST_ERR && clear)
            r_err_ovf <= 1'b0;
      end
   end

   nus_valid_pipe #(
      .DEPTH (VALID_DEPTH)
   ) u_valid_pipe (
      .clk_sys  (clk_sys),
      .resetb   (w_rstn),
      .flush    (w_flush),
      .in_valid (w_rd_en),
      .in_tag   (w_first),
      .valid_q  (w_valid_q),
      .tag_last (w_tag_last)
   );

   assign fifo_rd_en  = w_rd_en;
   assign parse_valid = w_valid_q[PARSE_TAP];
   assign dt_valid    = w_valid_q[VALID_DEPTH-1];
   assign dt0_valid   = w_valid_q[VALID_DEPTH-1] & ~w_tag_last;
   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign word_cnt    = r_word_cnt;
   assign err_ovf     = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nus_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nus_capture_ctrl : directed scoreboard bench for nus_capture_ctrl |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nus_capture_ctrl;

   localparam int LAT = 1;

   logic        clk_sys = 1'b0;
   logic        resetb;
   logic        start, stop, clear, fifo_empty, fifo_ovf;
   logic [15:0] burst_len;
   logic        fifo_rd_en, parse_valid, dt_valid, dt0_valid, busy, done, err_ovf;
   logic [15:0] word_cnt;

   typedef struct {int due; bit first;} dt_ent_t;

   int      q_pv[$];
   dt_ent_t q_dt[$];
   int      cyc = 0;
   int      errors = 0;
   int      checks = 0;
   bit      first_pend = 1'b0;
   logic    e_t;

   always #5 clk_sys = ~clk_sys;

   nus_capture_ctrl #(.FIFO_RD_LAT(LAT)) dut (
      .clk_sys     (clk_sys),
      .resetb      (resetb),
      .start       (start),
      .stop        (stop),
      .clear       (clear),
      .burst_len   (burst_len),
      .fifo_empty  (fifo_empty),
      .fifo_ovf    (fifo_ovf),
      .fifo_rd_en  (fifo_rd_en),
      .parse_valid (parse_valid),
      .dt_valid    (dt_valid),
      .dt0_valid   (dt0_valid),
      .busy        (busy),
      .done        (done),
      .word_cnt    (word_cnt),
      .err_ovf     (err_ovf)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock of stimulus: in = {start,stop,empty,ovf,clear}, x = {rd_en,done,busy}.
   task automatic step(input logic [4:0] in, input logic [2:0] x);
      logic exp_pv, exp_dt, exp_dt0;
      {start, stop, fifo_empty, fifo_ovf, clear} = in;
      @(negedge clk_sys);
      check1("rd_en", fifo_rd_en, x[2]);
      check1("done", done, x[1]);
      check1("busy", busy, x[0]);
      exp_pv = (q_pv.size() != 0) && (q_pv[0] == cyc);
      if (exp_pv) void'(q_pv.pop_front());
      check1("parse_valid", parse_valid, exp_pv);
      exp_dt  = (q_dt.size() != 0) && (q_dt[0].due == cyc);
      exp_dt0 = 1'b0;
      if (exp_dt) begin
         exp_dt0 = !q_dt[0].first;
         void'(q_dt.pop_front());
      end
      check1("dt_valid", dt_valid, exp_dt);
      check1("dt0_valid", dt0_valid, exp_dt0);
      if (in[1]) begin
         q_pv.delete();
         q_dt.delete();
      end else if (x[2]) begin
         q_pv.push_back(cyc + LAT + 2);
         q_dt.push_back('{cyc + LAT + 3, first_pend});
         first_pend = 1'b0;
      end
      if (in[4] && !in[3] && !x[0]) first_pend = 1'b1;
      @(posedge clk_sys);
      #1;
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      resetb = 1'b0;
      burst_len = 16'd0;
      {start, stop, fifo_empty, fifo_ovf, clear} = 5'b00000;
      #1;
      check16("rst_word_cnt", word_cnt, 16'd0);
      check1("rst_err_ovf", err_ovf, 1'b0);
      repeat (2) step(5'b00000, 3'b000);
      resetb = 1'b1;
      repeat (3) step(5'b00000, 3'b000);

      // Fixed burst of 4; mid-capture burst_len change must be ignored.
      burst_len = 16'd4;
      step(5'b10000, 3'b000);
      step(5'b00000, 3'b101);
      burst_len = 16'd2;
      repeat (3) step(5'b00000, 3'b101);
      repeat (4) step(5'b00000, 3'b001);
      step(5'b00000, 3'b010);
      check16("burst_word_cnt", word_cnt, 16'd4);
      step(5'b00000, 3'b000);

      // Continuous with bubbles, then stop.
      burst_len = 16'd0;
      step(5'b10100, 3'b000);
      for (int i = 1; i <= 6; i++) begin
         e_t = (i % 2 == 1);
         step({2'b00, e_t, 2'b00}, {~e_t, 2'b01});
      end
      step(5'b01000, 3'b001);
      repeat (3) step(5'b00000, 3'b001);
      step(5'b00000, 3'b010);
      check16("cont_word_cnt", word_cnt, 16'd3);
      check1("cont_busy", busy, 1'b0);

      // Overflow during burst of 8.
      burst_len = 16'd8;
      step(5'b10000, 3'b000);
      repeat (2) step(5'b00000, 3'b101);
      step(5'b00110, 3'b001);
      step(5'b00000, 3'b001);
      check1("err_ovf_set", err_ovf, 1'b1);
      step(5'b10000, 3'b001);
      repeat (2) step(5'b00000, 3'b001);
      step(5'b00001, 3'b001);
      check1("err_ovf_clr", err_ovf, 1'b0);
      step(5'b00000, 3'b000);

      // start+stop together stays idle.
      step(5'b11000, 3'b000);
      step(5'b00000, 3'b000);

      // Reset mid-run.
      burst_len = 16'd0;
      step(5'b10000, 3'b000);
      repeat (3) step(5'b00000, 3'b101);
      #1;
      check1("prerst_parse", parse_valid, 1'b1);
      check1("prerst_rd_en", fifo_rd_en, 1'b1);
      resetb = 1'b0;
      #1;
      check1("rst_rd_en", fifo_rd_en, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_parse", parse_valid, 1'b0);
      check1("rst_dt", dt_valid, 1'b0);
      check16("rst_cnt", word_cnt, 16'd0);
      q_pv.delete();
      q_dt.delete();
      first_pend = 1'b0;
      @(posedge clk_sys);
      #1;
      cyc++;
      repeat (2) step(5'b00000, 3'b000);
      resetb = 1'b1;
      repeat (8) step(5'b00000, 3'b000);

      check16("scoreboard_empty", 16'(q_pv.size() + q_dt.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
